// File: rtl/multi_bank_stream_reader.sv
// Read-side master for the multi-bank BRAM: issues the same address to every bank,
// buffers the returned words and emits one BANKS*WIDTH-wide AXI-Stream beat per address.
module multi_bank_stream_reader #(
    parameter int BANKS      = 4,
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR       = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR-1:0]        base_addr,
    input  logic [ADDR:0]          count,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [BANKS-1:0]       enb,
    output logic [BANKS*ADDR-1:0]  addrb,
    input  logic [BANKS*WIDTH-1:0] doutb,
    input  logic [BANKS-1:0]       validb,
    output logic [BANKS*WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = BANKS * WIDTH;
    localparam logic [ADDR:0] XFER_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW:0]   CREDITS  = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state;

    logic [ADDR:0]   count_r;
    logic [ADDR:0]   issued;
    logic [ADDR:0]   beat_cnt;
    logic [ADDR-1:0] rd_addr;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   fifo_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [BW-1:0]   fifo_mem [FIFO_DEPTH];

    logic          active;
    logic          push;
    logic          pop;
    logic          issue;
    logic          mismatch;
    logic [CW:0]   credits_used;

    // Returns are only accepted while a transfer is live, so data still in
    // flight from an aborted transfer is dropped after reset.
    assign active       = (state == RUN) || (state == DRAIN);
    assign push         = active && validb[0];
    assign pop          = m_axis_tvalid && m_axis_tready;
    assign mismatch     = active && (validb != '0) && (validb != '1);
    assign credits_used = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign issue        = (state == RUN) && (issued < count_r) && (credits_used < CREDITS);

    assign m_axis_tvalid = (fifo_cnt != '0);
    assign m_axis_tdata  = fifo_mem[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == count_r - XFER_ONE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= doutb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            enb         <= '0;
            addrb       <= '0;
            count_r     <= '0;
            issued      <= '0;
            beat_cnt    <= '0;
            rd_addr     <= '0;
            outstanding <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            done <= 1'b0;
            enb  <= {BANKS{issue}};
            if (issue) begin
                addrb   <= {BANKS{rd_addr}};
                rd_addr <= rd_addr + 1'b1;
                issued  <= issued + 1'b1;
            end
            if (mismatch) begin
                err <= 1'b1;
            end

            case ({issue, push})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        count_r  <= count;
                        rd_addr  <= base_addr;
                        issued   <= '0;
                        beat_cnt <= '0;
                        if (count == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued == count_r) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish on the final handshake itself so done lands one cycle later.
                    if (outstanding == '0 &&
                        (fifo_cnt == '0 || (fifo_cnt == CNT_ONE && pop))) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_cnt == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_multi_bank_stream_reader.sv
// Scoreboard bench for multi_bank_stream_reader with a one-cycle-latency BRAM model.
module tb_multi_bank_stream_reader;
    localparam int BANKS = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int ADDR  = 8;
    localparam int FD    = 4;
    localparam int L     = 1;
    localparam int BW    = BANKS * WIDTH;
    localparam int CNTW  = ADDR + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [ADDR-1:0] base_addr;
    logic [ADDR:0] count;
    logic busy, done, err;
    logic [BANKS-1:0] enb;
    logic [BANKS*ADDR-1:0] addrb;
    logic [BW-1:0] doutb;
    logic [BANKS-1:0] validb;
    logic [BW-1:0] m_axis_tdata;
    logic m_axis_tvalid, m_axis_tready, m_axis_tlast;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    multi_bank_stream_reader #(
        .BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .err(err), .enb(enb), .addrb(addrb),
        .doutb(doutb), .validb(validb),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    // BRAM model: bank b at address a holds (b<<12)|a; not affected by DUT reset.
    logic [BANKS-1:0] en_d = '0;
    logic [BANKS*ADDR-1:0] ad_d = '0;
    logic [BANKS-1:0] vmask = '1;
    logic [BANKS-1:0] vforce = '0;
    always @(posedge clk) begin
        en_d <= enb;
        ad_d <= addrb;
    end
    always_comb begin
        validb = (en_d & vmask) | vforce;
        for (int b = 0; b < BANKS; b++)
            doutb[b*WIDTH +: WIDTH] = 16'(b << 12) | 16'(ad_d[b*ADDR +: ADDR]);
    end

    int npass = 0;
    int ntot = 0;
    logic [BW:0] exp_q[$];
    logic [ADDR-1:0] addr_q[$];
    bit bp_mode = 0;
    bit chk_credit = 0;
    int en_cnt = 0, first_en = 0, last_en = 0;
    int tv_cycles = 0, first_tv = 0, last_cyc = 0;
    int done_cnt = 0, done_cyc = 0, d0 = 0, cur_cnt = 0;
    int tb_out = 0, tb_fifo = 0;
    bit en_seen = 0, tv_seen = 0, prev_stall = 0;
    logic [BW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] beat(input int a);
        logic [BW-1:0] r;
        for (int b = 0; b < BANKS; b++)
            r[b*WIDTH +: WIDTH] = 16'((b << 12) | a);
        return r;
    endfunction

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = bp_mode ? ((cyc % 4) == 0) : 1'b1;
        end
    end

    // Monitor: reads, beats, stall stability, done pulses, credit bound.
    always @(negedge clk) begin
        logic [BW:0] e;
        logic [ADDR-1:0] a;
        bit hs;
        hs = m_axis_tvalid && m_axis_tready;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (enb != '0) begin
                en_cnt++;
                if (!en_seen) begin en_seen = 1; first_en = cyc; end
                last_en = cyc;
                if (addr_q.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_read: got addrb %0h expected no read", addrb);
                end else begin
                    a = addr_q.pop_front();
                    chk("read_addr", 128'({enb, addrb}), 128'({{BANKS{1'b1}}, {BANKS{a}}}));
                end
            end
            if (m_axis_tvalid) begin
                tv_cycles++;
                if (!tv_seen) begin tv_seen = 1; first_tv = cyc; end
            end
            if (prev_stall)
                chk("stall_hold", 128'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                    128'({1'b1, prev_last, prev_data}));
            if (hs) begin
                if (exp_q.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 128'({m_axis_tlast, m_axis_tdata}), 128'(e));
                end
                if (m_axis_tlast) last_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (chk_credit) begin
                if (enb[0]) begin
                    tb_out++;
                    chk("credit_bound", 128'(tb_out + tb_fifo <= FD), 128'(1));
                end
                if (validb[0]) begin tb_out--; tb_fifo++; end
                if (hs) tb_fifo--;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    task automatic xfer_begin(input int base, input int cnt, input bit bp);
        for (int k = 0; k < cnt; k++) begin
            exp_q.push_back({(k == cnt - 1), beat((base + k) % DEPTH)});
            addr_q.push_back(ADDR'((base + k) % DEPTH));
        end
        en_cnt = 0; en_seen = 0; tv_cycles = 0; tv_seen = 0;
        tb_out = 0; tb_fifo = 0; d0 = done_cnt; cur_cnt = cnt;
        bp_mode = bp;
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR'(base); count = CNTW'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(cnt > 0));
    endtask

    task automatic xfer_end();
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("done_pulse", 128'(done_cnt - d0), 128'(1));
        if (cur_cnt > 0) chk("done_after_tlast", 128'(done_cyc - last_cyc), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("done_once", 128'(done_cnt - d0), 128'(1));
        chk("busy_idle", 128'(busy), 128'(0));
        chk("beats_left", 128'(exp_q.size()), 128'(0));
        chk("reads_left", 128'(addr_q.size()), 128'(0));
        exp_q.delete();
        addr_q.delete();
        bp_mode = 0;
    endtask

    task automatic run(input int base, input int cnt, input bit bp);
        xfer_begin(base, cnt, bp);
        xfer_end();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int dbefore;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({busy, done, err, enb, addrb, m_axis_tvalid, m_axis_tlast}), 128'(0));
        rst_n = 1'b1;

        run(0, 8, 0);
        chk("issue_span", 128'(last_en - first_en + 1), 128'(8));
        chk("issue_count", 128'(en_cnt), 128'(8));
        chk("first_beat_latency", 128'(first_tv - first_en), 128'(L + 1));

        chk_credit = 1;
        run(32, 16, 1);
        chk_credit = 0;
        chk("bp_enb_gaps", 128'((last_en - first_en + 1) > en_cnt), 128'(1));
        chk("bp_reads", 128'(en_cnt), 128'(16));

        run(254, 4, 0);

        run(0, 0, 0);
        chk("zero_no_enb", 128'(en_cnt), 128'(0));
        chk("zero_no_tvalid", 128'(tv_cycles), 128'(0));

        run(0, 256, 0);
        chk("full_reads", 128'(en_cnt), 128'(256));

        xfer_begin(10, 12, 0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 8'd100; count = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        xfer_end();
        run(100, 3, 0);

        xfer_begin(40, 6, 0);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (validb == '0 && t < 50);
        chk("inject_found_return", 128'(validb), 128'(4'hF));
        vmask = 4'b0111;
        @(posedge clk); #1;
        vmask = 4'hF;
        chk("err_set", 128'(err), 128'(1));
        xfer_end();
        run(60, 2, 0);
        chk("err_sticky", 128'(err), 128'(1));

        xfer_begin(20, 16, 1);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", 128'({busy, done, err, enb, addrb, m_axis_tvalid, m_axis_tlast}), 128'(0));
        dbefore = done_cnt;
        exp_q.delete();
        addr_q.delete();
        bp_mode = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tv_cycles = 0;
        vforce = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        vforce = 4'h0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 128'(done_cnt), 128'(dbefore));
        chk("abort_no_tvalid", 128'(tv_cycles), 128'(0));
        chk("abort_idle", 128'({busy, err}), 128'(0));

        run(0, 8, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
